sa_instr_sequencer: RTL and testbench

//  Program sequencer for the 4x4 systolic array. On ap_start it fetches 4-bit opcodes from the
//  8-entry instruction memory and runs each one: preload B, stream A, clear accumulators, store results.

---
 rtl/sa_instr_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_sa_instr_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_instr_sequencer.sv
// Program sequencer for the 4x4 systolic array.
// Fetches opcodes from a small synchronous instruction memory and steps the
// operand banks, array control strobes and output-memory port through each
// instruction. All control outputs are registered and aligned to the state
// they belong to, so they are computed from the next-state values.
module sa_instr_sequencer #(
  parameter int N   = 4,
  parameter int IAW = 3,
  parameter int IW  = 4,
  parameter int CW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ap_start,
  output logic           ap_done,
  output logic           ap_idle,
  output logic           instr_rd,
  output logic [IAW-1:0] instr_addr,
  input  logic [IW-1:0]  instr_data,
  output logic [IW-1:0]  curr_instr,
  output logic           rd_en_a,
  output logic           rd_en_b,
  output logic [CW-1:0]  rd_col,
  output logic           arr_load_b,
  output logic           arr_shift,
  output logic           arr_clear,
  output logic           out_wr,
  output logic [CW-1:0]  out_addr,
  output logic           err_illegal
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } stateT;

  localparam logic [IW-1:0] OP_NOP     = IW'(0);
  localparam logic [IW-1:0] OP_HALT    = IW'(1);
  localparam logic [IW-1:0] OP_COMPUTE = IW'(2);
  localparam logic [IW-1:0] OP_CLEAR   = IW'(3);
  localparam logic [IW-1:0] OP_LOAD_B  = IW'(4);
  localparam logic [IW-1:0] OP_STORE   = IW'(5);

  // Instruction lengths in EXEC cycles
  localparam logic [CW-1:0] LEN_COMPUTE = CW'(3*N-1);
  localparam logic [CW-1:0] LEN_CLEAR   = CW'(1);
  localparam logic [CW-1:0] LEN_LOAD_B  = CW'(2*N);
  localparam logic [CW-1:0] LEN_STORE   = CW'(N*N);

  // Last column of a skewed operand row; later COMPUTE cycles only flush the skew
  localparam logic [CW-1:0] LAST_COL = CW'(2*N-2);

  localparam logic [IAW-1:0] LAST_PC = {IAW{1'b1}};

  stateT          state, stateNext;
  logic [IAW-1:0] pc, pcNext;
  logic [CW-1:0]  cnt, cntNext;
  logic [IW-1:0]  currReg, currNext;
  logic           errReg, errNext;
  logic [CW-1:0]  execLen;

  logic           doneNext, idleNext, instrRdNext;
  logic           rdEnANext, rdEnBNext, loadBNext, shiftNext, clearNext, outWrNext;
  logic [CW-1:0]  rdColNext, outAddrNext;

  // State register together with pc, cycle counter, latched opcode and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      cnt     <= '0;
      currReg <= '0;
      errReg  <= 1'b0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      cnt     <= cntNext;
      currReg <= currNext;
      errReg  <= errNext;
    end
  end

  // Number of EXEC cycles for the instruction currently executing
  always_comb begin
    execLen = LEN_CLEAR;
    case (currReg)
      OP_COMPUTE: execLen = LEN_COMPUTE;
      OP_CLEAR:   execLen = LEN_CLEAR;
      OP_LOAD_B:  execLen = LEN_LOAD_B;
      OP_STORE:   execLen = LEN_STORE;
      default:    execLen = LEN_CLEAR;
    endcase
  end

  // Next-state logic: program flow, implicit halt at the last address, no pc wrap
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    cntNext   = cnt;
    currNext  = currReg;
    errNext   = errReg;
    case (state)
      IDLE: begin
        if (ap_start) begin
          stateNext = FETCH;
          pcNext    = '0;
          errNext   = 1'b0;
        end
      end
      FETCH: begin
        stateNext = DECODE;
      end
      DECODE: begin
        currNext = instr_data;
        cntNext  = '0;
        case (instr_data)
          OP_NOP: begin
            if (pc == LAST_PC) begin
              stateNext = DONE;
            end else begin
              pcNext    = pc + 1'b1;
              stateNext = FETCH;
            end
          end
          OP_HALT: stateNext = DONE;
          OP_COMPUTE, OP_CLEAR, OP_LOAD_B, OP_STORE: stateNext = EXEC;
          default: begin
            errNext   = 1'b1;
            stateNext = DONE;
          end
        endcase
      end
      EXEC: begin
        if (cnt == execLen - 1'b1) begin
          cntNext = '0;
          if (pc == LAST_PC) begin
            stateNext = DONE;
          end else begin
            pcNext    = pc + 1'b1;
            stateNext = FETCH;
          end
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Output decode from next state/counter/opcode so the registered strobes line up with their state
  always_comb begin
    doneNext    = (stateNext == DONE);
    idleNext    = (stateNext == IDLE);
    instrRdNext = (stateNext == FETCH);
    rdEnANext   = 1'b0;
    rdEnBNext   = 1'b0;
    loadBNext   = 1'b0;
    shiftNext   = 1'b0;
    clearNext   = 1'b0;
    outWrNext   = 1'b0;
    rdColNext   = '0;
    outAddrNext = '0;
    if (stateNext == EXEC) begin
      case (currNext)
        OP_LOAD_B: begin
          if (cntNext <= LAST_COL) begin
            rdEnBNext = 1'b1;
            rdColNext = cntNext;
          end
          loadBNext = (cntNext != '0);
        end
        OP_COMPUTE: begin
          if (cntNext <= LAST_COL) begin
            rdEnANext = 1'b1;
            rdColNext = cntNext;
          end
          shiftNext = (cntNext != '0);
        end
        OP_CLEAR: begin
          clearNext = 1'b1;
        end
        OP_STORE: begin
          outWrNext   = 1'b1;
          outAddrNext = cntNext;
        end
        default: begin
          clearNext = 1'b0;
        end
      endcase
    end
  end

  // Output registers; the sequencer sits in IDLE after reset, so ap_idle comes up high
  always_ff @(posedge clk) begin
    if (rst) begin
      ap_done    <= 1'b0;
      ap_idle    <= 1'b1;
      instr_rd   <= 1'b0;
      rd_en_a    <= 1'b0;
      rd_en_b    <= 1'b0;
      rd_col     <= '0;
      arr_load_b <= 1'b0;
      arr_shift  <= 1'b0;
      arr_clear  <= 1'b0;
      out_wr     <= 1'b0;
      out_addr   <= '0;
    end else begin
      ap_done    <= doneNext;
      ap_idle    <= idleNext;
      instr_rd   <= instrRdNext;
      rd_en_a    <= rdEnANext;
      rd_en_b    <= rdEnBNext;
      rd_col     <= rdColNext;
      arr_load_b <= loadBNext;
      arr_shift  <= shiftNext;
      arr_clear  <= clearNext;
      out_wr     <= outWrNext;
      out_addr   <= outAddrNext;
    end
  end

  assign instr_addr  = pc;
  assign curr_instr  = currReg;
  assign err_illegal = errReg;

endmodule

// File: tb/tb_sa_instr_sequencer.sv
// Directed testbench for sa_instr_sequencer.
// Each program run is checked cycle by cycle against hand-derived timelines,
// with cycle 1 being the first FETCH after the accepted ap_start.
module tb_sa_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       apStart;
  logic       apDone;
  logic       apIdle;
  logic       instrRd;
  logic [2:0] instrAddr;
  logic [3:0] instrData;
  logic [3:0] currInstr;
  logic       rdEnA;
  logic       rdEnB;
  logic [7:0] rdCol;
  logic       arrLoadB;
  logic       arrShift;
  logic       arrClear;
  logic       outWr;
  logic [7:0] outAddr;
  logic       errIllegal;

  logic [3:0] prog [0:7];

  int compareCount  = 0;
  int mismatchCount = 0;

  sa_instr_sequencer #(.N(4), .IAW(3), .IW(4), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ap_start   (apStart),
    .ap_done    (apDone),
    .ap_idle    (apIdle),
    .instr_rd   (instrRd),
    .instr_addr (instrAddr),
    .instr_data (instrData),
    .curr_instr (currInstr),
    .rd_en_a    (rdEnA),
    .rd_en_b    (rdEnB),
    .rd_col     (rdCol),
    .arr_load_b (arrLoadB),
    .arr_shift  (arrShift),
    .arr_clear  (arrClear),
    .out_wr     (outWr),
    .out_addr   (outAddr),
    .err_illegal(errIllegal)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Synchronous-read instruction memory model
  always @(posedge clk) begin
    if (instrRd) instrData <= prog[instrAddr];
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Program word: nibble i is instruction i
  task automatic loadProgram(input logic [31:0] word);
    for (int i = 0; i < 8; i++) prog[i] = word[i*4 +: 4];
  endtask

  function automatic bit isFetch(input int t, input int k);
    case (t)
      1: return k inside {1, 11, 13, 26};
      2: return k inside {1, 4, 22};
      3: return (k <= 15) && (k % 2 == 1);
      4: return k inside {1, 3};
      5: return k inside {1, 4};
      6: return k == 1;
      7: return k inside {1, 14};
      default: return 1'b0;
    endcase
  endfunction

  function automatic int doneCycle(input int t);
    case (t)
      1: return 28;
      2: return 24;
      3: return 17;
      4: return 5;
      5: return 6;
      7: return 16;
      default: return 1000;
    endcase
  endfunction

  task automatic checkCycle(input int t, input int c);
    int eIdle, eRd, ePc, eRdA, eRdB, eCol, eLoad, eShift, eClear, eWr, eAddr, eErr, eCurr, fetches;
    bit chkCurr;
    string p;
    eRdA = 0; eRdB = 0; eCol = 0; eLoad = 0; eShift = 0; eClear = 0;
    eWr = 0; eAddr = 0; eErr = 0; eCurr = 0; chkCurr = 1'b0;
    p = $sformatf("t%0d c%0d", t, c);
    fetches = 0;
    for (int k = 1; k <= c; k++) if (isFetch(t, k)) fetches++;
    ePc   = fetches - 1;
    eRd   = isFetch(t, c) ? 1 : 0;
    eIdle = (c > doneCycle(t)) ? 1 : 0;
    case (t)
      1: begin
        if (c inside {[3:9]})   begin eRdB = 1; eCol = c - 3;  end
        if (c inside {[15:21]}) begin eRdA = 1; eCol = c - 15; end
        eLoad  = (c inside {[4:10]})  ? 1 : 0;
        eShift = (c inside {[16:25]}) ? 1 : 0;
        if (c inside {[3:10]})  begin chkCurr = 1'b1; eCurr = 4; end
        if (c inside {[13:14]}) begin chkCurr = 1'b1; eCurr = 0; end
        if (c inside {[15:25]}) begin chkCurr = 1'b1; eCurr = 2; end
        if (c >= 28)            begin chkCurr = 1'b1; eCurr = 1; end
      end
      2: begin
        eClear = (c == 3) ? 1 : 0;
        if (c inside {[6:21]}) begin eWr = 1; eAddr = c - 6; chkCurr = 1'b1; eCurr = 5; end
        if (c == 3)  begin chkCurr = 1'b1; eCurr = 3; end
        if (c >= 24) begin chkCurr = 1'b1; eCurr = 1; end
      end
      3: begin
        if (c >= 3) begin chkCurr = 1'b1; eCurr = 0; end
      end
      4: begin
        eErr = (c >= 5) ? 1 : 0;
        if (c >= 5) begin chkCurr = 1'b1; eCurr = 9; end
      end
      5: begin
        eClear = (c == 3) ? 1 : 0;
        if (c == 3) begin chkCurr = 1'b1; eCurr = 3; end
        if (c >= 6) begin chkCurr = 1'b1; eCurr = 1; end
      end
      6: begin
        if (c <= 8) begin
          if (c >= 3) begin eRdA = 1; eCol = c - 3; chkCurr = 1'b1; eCurr = 2; end
          eShift = (c >= 4) ? 1 : 0;
        end else begin
          eIdle = 1; ePc = 0; chkCurr = 1'b1; eCurr = 0;
        end
      end
      7: begin
        if (c inside {[3:9]}) begin eRdA = 1; eCol = c - 3; end
        eShift = (c inside {[4:13]}) ? 1 : 0;
        if (c inside {[3:13]}) begin chkCurr = 1'b1; eCurr = 2; end
        if (c >= 16)           begin chkCurr = 1'b1; eCurr = 1; end
      end
      default: ;
    endcase
    checkOutput({p, " apDone"},     apDone,     (c == doneCycle(t)) ? 1 : 0);
    checkOutput({p, " apIdle"},     apIdle,     eIdle);
    checkOutput({p, " instrRd"},    instrRd,    eRd);
    checkOutput({p, " instrAddr"},  instrAddr,  ePc);
    checkOutput({p, " rdEnA"},      rdEnA,      eRdA);
    checkOutput({p, " rdEnB"},      rdEnB,      eRdB);
    checkOutput({p, " rdCol"},      rdCol,      eCol);
    checkOutput({p, " arrLoadB"},   arrLoadB,   eLoad);
    checkOutput({p, " arrShift"},   arrShift,   eShift);
    checkOutput({p, " arrClear"},   arrClear,   eClear);
    checkOutput({p, " outWr"},      outWr,      eWr);
    checkOutput({p, " outAddr"},    outAddr,    eAddr);
    checkOutput({p, " errIllegal"}, errIllegal, eErr);
    if (chkCurr) checkOutput({p, " currInstr"}, currInstr, eCurr);
  endtask

  // Start one run, optionally holding ap_start high or pulsing reset mid-run, and check every cycle
  task automatic applyStimulus(input int t, input int lastCycle, input int holdUntil, input int resetAt);
    @(negedge clk);
    apStart = 1'b1;
    @(posedge clk);
    #1;
    if (holdUntil == 0) apStart = 1'b0;
    for (int c = 1; c <= lastCycle; c++) begin
      @(negedge clk);
      checkCycle(t, c);
      if (c == holdUntil) apStart = 1'b0;
      if (rst) rst = 1'b0;
      else if (c == resetAt) rst = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    apStart   = 1'b0;
    instrData = '0;
    loadProgram(32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset apIdle",     apIdle,     1);
    checkOutput("reset apDone",     apDone,     0);
    checkOutput("reset instrRd",    instrRd,    0);
    checkOutput("reset instrAddr",  instrAddr,  0);
    checkOutput("reset currInstr",  currInstr,  0);
    checkOutput("reset rdCol",      rdCol,      0);
    checkOutput("reset outWr",      outWr,      0);
    checkOutput("reset errIllegal", errIllegal, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // LOAD_B, NOP, COMPUTE, HALT
    loadProgram(32'h0000_1204);
    applyStimulus(1, 30, 0, 0);
    // CLEAR, STORE, HALT
    loadProgram(32'h0000_0153);
    applyStimulus(2, 26, 0, 0);
    // All NOPs: implicit halt at the last address, pc stays at 7
    loadProgram(32'h0000_0000);
    applyStimulus(3, 19, 0, 0);
    // Illegal opcode 9 at address 1
    loadProgram(32'h0000_0090);
    applyStimulus(4, 7, 0, 0);
    // ap_start held through the run: single run, sticky error cleared on accept
    loadProgram(32'h0000_0013);
    applyStimulus(5, 12, 6, 0);
    // Reset during COMPUTE cnt=5 aborts without ap_done
    loadProgram(32'h0000_0012);
    applyStimulus(6, 14, 0, 8);
    // Normal rerun after the abort
    applyStimulus(7, 18, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
